// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: keeps every DECIM-th valid filter sample and buffers the kept
// samples in a DEPTH-entry FIFO. The FIFO drains through a valid/ready port.
// Kept samples that find the FIFO full (with no pop) are dropped and flagged in
// a sticky overflow bit. The upstream filter is never stalled.
module fir_decim_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DECIM  = 4,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   input  logic                       phase_clr,
   input  logic                       ovf_clr,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic [PW-1:0] PH_LAST      = PW'(DECIM - 1);
   localparam logic [PW-1:0] PH_AFTER_CLR = (DECIM == 1) ? '0 : PW'(1);
   localparam logic [LW-1:0] LVL_FULL     = LW'(DEPTH);

   logic [PW-1:0]     ph;
   logic [PW-1:0]     ph_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              keep;
   logic              full;
   logic              push;
   logic              pop;
   logic              drop;

   // Keep/push/pop/drop decisions for the current cycle.
   always_comb begin
      keep = in_valid && (phase_clr || (ph == '0));
      full = (level == LVL_FULL);
      pop  = out_valid && out_ready;
      push = keep && (!full || pop);
      drop = keep && full && !pop;
   end

   // Next decimation phase; phase_clr on a valid sample keeps it and restarts counting after it.
   always_comb begin
      ph_nxt = ph;
      if (phase_clr) begin
         ph_nxt = in_valid ? PH_AFTER_CLR : '0;
      end else if (in_valid) begin
         ph_nxt = (ph == PH_LAST) ? '0 : ph + PW'(1);
      end
   end

   // Decimation phase register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ph <= '0;
      end else begin
         ph <= ph_nxt;
      end
   end

   // Sample storage; written only on a successful push.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Read/write pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // Occupancy count; simultaneous push and pop leave it unchanged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level <= '0;
      end else begin
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Sticky overflow; a drop in the same cycle as ovf_clr keeps the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   // Head of FIFO and non-empty indication, both derived from registered state.
   always_comb begin
      out_data  = mem[rd_ptr];
      out_valid = (level != '0);
   end

endmodule
